// File: rtl/riscv_lsu.sv
// Load/store unit: turns one core access into a word-aligned bus transaction
// with byte strobes and returns extended load data, with misalign and timeout errors.
module riscv_lsu #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_valid,
    input  logic        cpu_wen,
    input  logic [2:0]  cpu_memop,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_done,
    output logic        cpu_err,
    output logic        stall,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

    state_t      state;
    logic        wen_q;
    logic [2:0]  op_q;
    logic [1:0]  off_q;
    logic [15:0] cnt;

    logic        illegal;
    logic        misal;
    logic        rsp_take;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_strb;

    assign illegal = (cpu_memop == 3'b011) || (cpu_memop[2:1] == 2'b11) ||
                     (cpu_memop[2] && cpu_wen);
    assign misal   = ((cpu_memop[1:0] == 2'b01) && cpu_addr[0]) ||
                     ((cpu_memop[1:0] == 2'b10) && (cpu_addr[1:0] != 2'b00));

    // A response in the same cycle as request acceptance completes the access.
    assign rsp_take = ((state == REQ) && bus_req_ready && bus_rsp_valid) ||
                      ((state == WAIT) && bus_rsp_valid);

    assign stall = cpu_valid & ~cpu_done;

    always_comb begin
        lane_wdata = cpu_wdata;
        lane_strb  = 4'b1111;
        case (cpu_memop[1:0])
            2'b00: begin
                lane_wdata = {4{cpu_wdata[7:0]}};
                lane_strb  = 4'b0001 << cpu_addr[1:0];
            end
            2'b01: begin
                lane_wdata = {2{cpu_wdata[15:0]}};
                lane_strb  = 4'b0011 << cpu_addr[1:0];
            end
            default: begin
                lane_wdata = cpu_wdata;
                lane_strb  = 4'b1111;
            end
        endcase
    end

    function automatic logic [31:0] load_ext(input logic [2:0]  op,
                                             input logic [1:0]  off,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (op)
            3'b000:  load_ext = {{24{b[7]}}, b};
            3'b001:  load_ext = {{16{h[15]}}, h};
            3'b100:  load_ext = {24'd0, b};
            3'b101:  load_ext = {16'd0, h};
            default: load_ext = w;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            wen_q         <= 1'b0;
            op_q          <= 3'd0;
            off_q         <= 2'd0;
            cnt           <= 16'd0;
            cpu_rdata     <= 32'd0;
            cpu_done      <= 1'b0;
            cpu_err       <= 1'b0;
            bus_req_valid <= 1'b0;
            bus_we        <= 1'b0;
            bus_addr      <= 32'd0;
            bus_wdata     <= 32'd0;
            bus_wstrb     <= 4'd0;
        end else begin
            cpu_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_valid) begin
                        wen_q <= cpu_wen;
                        op_q  <= cpu_memop;
                        off_q <= cpu_addr[1:0];
                        cnt   <= 16'd0;
                        if (illegal || misal) begin
                            state     <= DONE;
                            cpu_done  <= 1'b1;
                            cpu_err   <= 1'b1;
                            cpu_rdata <= 32'd0;
                        end else begin
                            state         <= REQ;
                            bus_req_valid <= 1'b1;
                            bus_we        <= cpu_wen;
                            bus_addr      <= {cpu_addr[31:2], 2'b00};
                            bus_wdata     <= lane_wdata;
                            bus_wstrb     <= cpu_wen ? lane_strb : 4'b0000;
                        end
                    end
                end
                REQ, WAIT: begin
                    cnt <= cnt + 16'd1;
                    if (rsp_take) begin
                        state         <= DONE;
                        cpu_done      <= 1'b1;
                        cpu_err       <= 1'b0;
                        cpu_rdata     <= wen_q ? 32'd0 : load_ext(op_q, off_q, bus_rdata);
                        bus_req_valid <= 1'b0;
                    end else if (cnt == TO_LAST) begin
                        state         <= DONE;
                        cpu_done      <= 1'b1;
                        cpu_err       <= 1'b1;
                        cpu_rdata     <= 32'd0;
                        bus_req_valid <= 1'b0;
                    end else if ((state == REQ) && bus_req_ready) begin
                        state         <= WAIT;
                        bus_req_valid <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu: loads, stores, error paths, timeout and reset abort.
module tb_riscv_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_valid, cpu_wen;
    logic [2:0]  cpu_memop;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_done, cpu_err, stall;
    logic        bus_req_valid, bus_req_ready, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_rsp_valid;
    logic [31:0] bus_rdata;

    int n_vec  = 0;
    int n_miss = 0;

    riscv_lsu #(.TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst(rst),
        .cpu_valid(cpu_valid), .cpu_wen(cpu_wen), .cpu_memop(cpu_memop),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_done(cpu_done), .cpu_err(cpu_err), .stall(stall),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_wstrb(bus_wstrb), .bus_rsp_valid(bus_rsp_valid), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Results of the last access
    logic [31:0] r_rdata, r_addr, r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_err, r_we, r_req, r_stall_req, r_stall_done, r_req_after;
    int          r_cyc;

    task automatic access(input logic wen, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rword,
                          input int rsp_dly, input logic never_ready);
        int  wait_left;
        bit  done;
        wait_left = 0;
        done      = 0;
        r_req     = 0;
        r_cyc     = 0;
        r_stall_req = 0;
        @(negedge clk);
        cpu_wen   = wen;
        cpu_memop = op;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        bus_rdata = rword;
        cpu_valid = 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            @(posedge clk);
            #1;
            r_cyc++;
            bus_req_ready = 1'b0;
            bus_rsp_valid = 1'b0;
            if (cpu_done) begin
                r_rdata      = cpu_rdata;
                r_err        = cpu_err;
                r_stall_done = stall;
                r_req_after  = bus_req_valid;
                done         = 1;
            end else if (bus_req_valid) begin
                if (!r_req) begin
                    r_addr      = bus_addr;
                    r_wdata     = bus_wdata;
                    r_wstrb     = bus_wstrb;
                    r_we        = bus_we;
                    r_stall_req = stall;
                end
                r_req = 1;
                if (!never_ready) begin
                    bus_req_ready = 1'b1;
                    if (rsp_dly == 0) bus_rsp_valid = 1'b1;
                    else wait_left = rsp_dly;
                end
            end else if (wait_left > 0) begin
                wait_left--;
                if (wait_left == 0) bus_rsp_valid = 1'b1;
            end
        end
        cpu_valid = 1'b0;
        if (!done) chk("done_bound", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        chk("done_pulse", {31'd0, cpu_done}, 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        cpu_valid = 0; cpu_wen = 0; cpu_memop = 0; cpu_addr = 0; cpu_wdata = 0;
        bus_req_ready = 0; bus_rsp_valid = 0; bus_rdata = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", {cpu_rdata[7:0], bus_addr[7:0], 4'd0, bus_wstrb,
                         3'd0, cpu_done, cpu_err, bus_req_valid, bus_we, stall}, 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // LB 0x1003: byte 0x80 sign-extended, minimum latency
        access(1'b0, 3'b000, 32'h0000_1003, 32'd0, 32'h80FF_1234, 0, 1'b0);
        chk("lb_rdata", r_rdata, 32'hFFFF_FF80);
        chk("lb_err", {31'd0, r_err}, 32'd0);
        chk("lb_addr", r_addr, 32'h0000_1000);
        chk("lb_wstrb", {28'd0, r_wstrb}, 32'd0);
        chk("lb_we", {31'd0, r_we}, 32'd0);
        chk("lb_lat", r_cyc, 32'd2);
        chk("lb_stall_req", {31'd0, r_stall_req}, 32'd1);
        chk("lb_stall_done", {31'd0, r_stall_done}, 32'd0);

        // LHU through WAIT, then LH at the same address
        access(1'b0, 3'b101, 32'h0000_2002, 32'd0, 32'hBEEF_0001, 2, 1'b0);
        chk("lhu_rdata", r_rdata, 32'h0000_BEEF);
        chk("lhu_lat", r_cyc, 32'd4);
        access(1'b0, 3'b001, 32'h0000_2002, 32'd0, 32'hBEEF_0001, 1, 1'b0);
        chk("lh_rdata", r_rdata, 32'hFFFF_BEEF);

        access(1'b0, 3'b100, 32'h0000_1001, 32'd0, 32'h80FF_1234, 0, 1'b0);
        chk("lbu_rdata", r_rdata, 32'h0000_0012);
        access(1'b0, 3'b010, 32'h0000_4004, 32'd0, 32'hDEAD_BEEF, 0, 1'b0);
        chk("lw_rdata", r_rdata, 32'hDEAD_BEEF);

        // Stores
        access(1'b1, 3'b000, 32'h0000_3001, 32'h0000_00A5, 32'h1111_1111, 1, 1'b0);
        chk("sb_we", {31'd0, r_we}, 32'd1);
        chk("sb_wstrb", {28'd0, r_wstrb}, 32'h2);
        chk("sb_wdata", r_wdata, 32'hA5A5_A5A5);
        chk("sb_rdata", r_rdata, 32'd0);
        chk("sb_err", {31'd0, r_err}, 32'd0);
        access(1'b1, 3'b001, 32'h0000_3002, 32'h1234_BEEF, 32'd0, 0, 1'b0);
        chk("sh_wstrb", {28'd0, r_wstrb}, 32'hC);
        chk("sh_wdata", r_wdata, 32'hBEEF_BEEF);
        access(1'b1, 3'b010, 32'h0000_3004, 32'hCAFE_F00D, 32'd0, 0, 1'b0);
        chk("sw_wstrb", {28'd0, r_wstrb}, 32'hF);
        chk("sw_wdata", r_wdata, 32'hCAFE_F00D);

        // Error paths: no bus activity, done one cycle after accept
        access(1'b1, 3'b010, 32'h0000_4002, 32'h1, 32'd0, 0, 1'b0);
        chk("swmis_err", {31'd0, r_err}, 32'd1);
        chk("swmis_req", {31'd0, r_req}, 32'd0);
        chk("swmis_lat", r_cyc, 32'd1);
        chk("swmis_stall", {31'd0, r_stall_done}, 32'd0);
        access(1'b0, 3'b001, 32'h0000_2001, 32'd0, 32'd0, 0, 1'b0);
        chk("lhmis_err", {31'd0, r_err}, 32'd1);
        chk("lhmis_req", {31'd0, r_req}, 32'd0);
        access(1'b0, 3'b011, 32'h0000_0000, 32'd0, 32'd0, 0, 1'b0);
        chk("op011_err", {31'd0, r_err}, 32'd1);
        access(1'b1, 3'b100, 32'h0000_0000, 32'd0, 32'd0, 0, 1'b0);
        chk("sbu_err", {31'd0, r_err}, 32'd1);
        chk("sbu_req", {31'd0, r_req}, 32'd0);

        access(1'b0, 3'b010, 32'h0000_4004, 32'd0, 32'h0BAD_F00D, 0, 1'b0);
        chk("lw2_err", {31'd0, r_err}, 32'd0);

        // Timeout with ready held low: done 8 cycles after REQ entry
        access(1'b0, 3'b010, 32'h0000_6000, 32'd0, 32'h5555_5555, 0, 1'b1);
        chk("to_err", {31'd0, r_err}, 32'd1);
        chk("to_rdata", r_rdata, 32'd0);
        chk("to_lat", r_cyc, 32'd9);
        chk("to_reqv", {31'd0, r_req_after}, 32'd0);
        @(negedge clk);
        bus_rsp_valid = 1'b1;
        bus_rdata = 32'h7777_7777;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("late_done", {31'd0, cpu_done}, 32'd0);
        end
        bus_rsp_valid = 1'b0;
        chk("late_rdata", cpu_rdata, 32'd0);

        // Reset while in WAIT drops the access
        @(negedge clk);
        cpu_wen = 0; cpu_memop = 3'b010; cpu_addr = 32'h0000_5000; cpu_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("rw_req", {31'd0, bus_req_valid}, 32'd1);
        bus_req_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_req_ready = 1'b0;
        rst = 1'b0;
        #1;
        chk("rw_outs", {cpu_rdata[7:0], bus_addr[15:8], 4'd0, bus_wstrb,
                        4'd0, cpu_done, cpu_err, bus_req_valid, bus_we}, 32'd0);
        chk("rw_rdata", cpu_rdata, 32'd0);
        chk("rw_addr", bus_addr, 32'd0);
        cpu_valid = 1'b0;
        bus_rsp_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("rw_nodone", {31'd0, cpu_done}, 32'd0);
        bus_rsp_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        access(1'b0, 3'b010, 32'h0000_5004, 32'd0, 32'h1234_5678, 1, 1'b0);
        chk("post_rdata", r_rdata, 32'h1234_5678);
        chk("post_err", {31'd0, r_err}, 32'd0);
        chk("post_addr", r_addr, 32'h0000_5004);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
Load/store unit sitting directly downstream of the single-cycle core's memory outputs (memop, memdata, mem_wen, mem_addr) and upstream of its mem_data input. It converts one core access into a word-aligned bus transaction with byte strobes, then returns sign- or zero-extended load data. It detects misalignment, enforces a response timeout, and drives a stall while the access is in flight.

Parameters:
TIMEOUT_CYC, 255, cycles spent in REQ+WAIT before the access is aborted with error; range 1..65535.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
cpu_valid  input  1  core requests an access; held high until cpu_done
cpu_wen  input  1  1=store, 0=load
cpu_memop  input  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
cpu_addr  input  32  byte address
cpu_wdata  input  32  store data, right-aligned
cpu_rdata  output  32  extended load data; valid when cpu_done=1
cpu_done  output  1  one-cycle completion pulse
cpu_err  output  1  with cpu_done: misaligned, illegal memop, or timeout
stall  output  1  cpu_valid & ~cpu_done (combinational)
bus_req_valid  output  1  bus request valid
bus_req_ready  input  1  bus accepts request
bus_we  output  1  write request
bus_addr  output  32  {cpu_addr[31:2],2'b00}
bus_wdata  output  32  lane-replicated store data
bus_wstrb  output  4  byte strobes (0000 for reads)
bus_rsp_valid  input  1  read data / write ack
bus_rdata  input  32  read data word

Behaviour:
- Reset (rst=0, async): state IDLE; cpu_rdata=0, cpu_done=0, cpu_err=0, bus_req_valid=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_wstrb=0; timeout counter=0. Reset mid-transaction drops it; no cpu_done is issued.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: on cpu_valid, latch wen/memop/addr[1:0]/wdata. Illegal memop (011,110,111, or 100/101 with wen=1) or misaligned (H/HU addr[0]=1; W addr[1:0]!=00) -> DONE with err=1; no bus activity. Otherwise -> REQ with bus outputs registered.
- REQ: bus_req_valid=1, bus outputs stable; on bus_req_ready -> WAIT. If bus_rsp_valid arrives in the same cycle as bus_req_ready, it is taken as the response -> DONE.
- WAIT: bus_req_valid=0; on bus_rsp_valid capture and extend data -> DONE, err=0.
- Timeout: counter clears on leaving IDLE and increments every cycle in REQ or WAIT; when it equals TIMEOUT_CYC -> DONE, err=1, rdata=0, bus_req_valid dropped. Any later bus_rsp_valid outside WAIT/REQ is ignored.
- DONE: cpu_done=1 for exactly one cycle, cpu_rdata/cpu_err valid; -> IDLE. The core deasserts cpu_valid in the following cycle, so a new request is accepted no earlier than the cycle after DONE.
- Minimum latency (ready and response both in REQ): request cycle in IDLE, REQ, DONE = cpu_done 2 cycles after cpu_valid rises. Stores return rdata=0.
- Stores: SB wdata={4{b}}, wstrb=0001<<addr[1:0]; SH wdata={2{h}}, wstrb=0011<<addr[1:0]; SW wstrb=1111.
- Loads: byte/half selected by latched addr[1:0]. B/H sign-extend, BU/HU zero-extend, W passes through.
- cpu_rdata and cpu_err hold their values outside DONE. Only cpu_done qualifies them.

Test Plan:
- LB addr 0x1003, bus_rdata 0x80FF_1234 -> bus_addr 0x1000, wstrb 0000, cpu_rdata 0xFFFF_FF80, cpu_err=0.
- LHU addr 0x2002, bus_rdata 0xBEEF_0001 -> cpu_rdata 0x0000_BEEF; LH at the same address -> 0xFFFF_BEEF.
- SB addr 0x3001, wdata 0x0000_00A5 -> bus_we=1, wstrb 0010, bus_wdata 0xA5A5_A5A5; ack -> cpu_done, cpu_rdata 0.
- SW addr 0x4002 -> no bus_req_valid, cpu_done one cycle after IDLE accept, cpu_err=1, stall low after done.
- TIMEOUT_CYC=8, bus_req_ready held 0 -> cpu_done with err=1 exactly 8 cycles after entering REQ, bus_req_valid then 0; late bus_rsp_valid ignored.
- Assert rst=0 while in WAIT -> all outputs 0 immediately; next LW after release completes normally with rdata=bus_rdata.
